// File: rtl/net_router_pkg.sv
// Shared definitions for the ring router input unit: message field layout,
// output port encoding and the route decision.
package net_router_pkg;

  localparam int SRC_MSB     = 43;
  localparam int SRC_LSB     = 42;
  localparam int DEST_MSB    = 41;
  localparam int DEST_LSB    = 40;
  localparam int OPAQUE_MSB  = 39;
  localparam int OPAQUE_LSB  = 32;
  localparam int PAYLOAD_MSB = 31;
  localparam int PAYLOAD_LSB = 0;

  localparam logic [1:0] PORT_PREV = 2'd0;
  localparam logic [1:0] PORT_TERM = 2'd1;
  localparam logic [1:0] PORT_NEXT = 2'd2;

  // Ring distance masked to the ring size; the half-way tie goes to next.
  function automatic logic [1:0] route_port(input logic [7:0] dest,
                                            input logic [7:0] router_id,
                                            input int unsigned num_routers);
    logic [7:0] d_s;
    logic [1:0] port_s;
    d_s = (dest - router_id) & 8'(num_routers - 32'd1);
    if (d_s == 8'd0) begin
      port_s = PORT_TERM;
    end else if (d_s <= 8'(num_routers / 32'd2)) begin
      port_s = PORT_NEXT;
    end else begin
      port_s = PORT_PREV;
    end
    return port_s;
  endfunction

endpackage

// File: rtl/net_router_queue2.sv
// Two-entry circular FIFO with val/rdy on both sides and no enq/deq bypass.
module net_router_queue2 #(
  parameter int p_nbits = 44
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [p_nbits-1:0] enq_msg,
  input  logic               enq_val,
  output logic               enq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic               deq_val,
  input  logic               deq_rdy
);

  logic [p_nbits-1:0] entries_r [2];
  logic               head_r;
  logic               tail_r;
  logic [1:0]         count_r;
  logic               enq_fire_s;
  logic               deq_fire_s;

  // Ready depends only on occupancy, never on deq_rdy.
  assign enq_rdy    = rst_n && (count_r != 2'd2);
  assign deq_val    = (count_r != 2'd0);
  assign deq_msg    = entries_r[head_r];
  assign enq_fire_s = enq_val && enq_rdy;
  assign deq_fire_s = deq_val && deq_rdy;

  // Storage write; contents are left unreset since val gates them.
  always_ff @(posedge clk) begin
    if (enq_fire_s) begin
      entries_r[tail_r] <= enq_msg;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq_fire_s) begin
        tail_r <= tail_r + 1'b1;
      end
      if (deq_fire_s) begin
        head_r <= head_r + 1'b1;
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/net_router_input_unit.sv
// Ring router ingress: queues incoming messages and steers the head message
// to the prev, terminal or next output based on ring distance to dest.
module net_router_input_unit
  import net_router_pkg::*;
#(
  parameter int p_msg_nbits   = 44,
  parameter int p_num_routers = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [$clog2(p_num_routers)-1:0] router_id,
  input  logic [p_msg_nbits-1:0]           istream_msg,
  input  logic                             istream_val,
  output logic                             istream_rdy,
  output logic [p_msg_nbits-1:0]           ostream_msg [3],
  output logic [2:0]                       ostream_val,
  input  logic [2:0]                       ostream_rdy
);

  localparam int c_dest_nbits = $clog2(p_num_routers);

  logic [p_msg_nbits-1:0]  head_msg_s;
  logic                    head_val_s;
  logic                    head_rdy_s;
  logic [c_dest_nbits-1:0] dest_s;
  logic [1:0]              sel_s;

  net_router_queue2 #(.p_nbits(p_msg_nbits)) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .enq_msg (istream_msg),
    .enq_val (istream_val),
    .enq_rdy (istream_rdy),
    .deq_msg (head_msg_s),
    .deq_val (head_val_s),
    .deq_rdy (head_rdy_s)
  );

  assign dest_s = head_msg_s[DEST_LSB +: c_dest_nbits];
  assign sel_s  = route_port(8'(dest_s), 8'(router_id), p_num_routers);

  // Steer valid to the selected output and take ready only from it.
  always_comb begin
    ostream_val = 3'b000;
    head_rdy_s  = 1'b0;
    case (sel_s)
      PORT_PREV: begin
        ostream_val[0] = head_val_s;
        head_rdy_s     = ostream_rdy[0];
      end
      PORT_TERM: begin
        ostream_val[1] = head_val_s;
        head_rdy_s     = ostream_rdy[1];
      end
      PORT_NEXT: begin
        ostream_val[2] = head_val_s;
        head_rdy_s     = ostream_rdy[2];
      end
      default: begin
        ostream_val = 3'b000;
        head_rdy_s  = 1'b0;
      end
    endcase
  end

  // Head message is broadcast unmodified on all three outputs.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ostream_msg[i] = head_msg_s;
    end
  end

endmodule

// File: doc/net_router_input_unit.md
Name: net_router_input_unit

Overview:
- Ingress half of a ring router: accepts one network message stream and steers each message to one of three output streams (prev, terminal, next).
- Each output feeds the arbitrating switch unit of the corresponding router output.
- Holds messages in a 2-entry input queue, decides routing from the destination field, and applies val/rdy backpressure per output.

Parameters:
- p_msg_nbits, 44, total message width; field layout follows the net-msgs format.
- p_num_routers, 4, routers on the ring; a power of two, at least 2.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- router_id  input  $clog2(p_num_routers)  this router's ID; stable while out of reset.
- istream_msg  input  p_msg_nbits  incoming message.
- istream_val  input  1  incoming message valid.
- istream_rdy  output  1  queue can accept a message.
- ostream_msg[3]  output  p_msg_nbits  outgoing message, same value on all three.
- ostream_val[3]  output  1  per-output valid; at most one asserted.
- ostream_rdy[3]  input  1  per-output ready.

Behaviour:
- Message fields: src [43:42], dest [41:40], opaque [39:32], payload [31:0]. The dest width is $clog2(p_num_routers).
- Queue:
  - 2-entry circular FIFO with head pointer, tail pointer and a 2-bit count.
  - Enqueue when istream_val && istream_rdy.
  - istream_rdy = (count != 2). Do not combinationally bypass from deq ready, so there is no rdy path from output to input.
  - Dequeue when the selected ostream_val && ostream_rdy.
  - Simultaneous enq and deq: count unchanged, both pointers advance.
  - Pointers wrap 1 -> 0.
- Latency: a message enqueued at edge N is visible on ostream at cycle N+1. There is no same-cycle pass-through. Sustained throughput is 1 message/cycle when the selected output is always ready.
- Routing on the head message (combinational from queue state):
  - d = (dest - router_id) mod p_num_routers, computed in dest width so it wraps naturally.
  - d == 0 -> output 1 (terminal).
  - 1 <= d <= p_num_routers/2 -> output 2 (next). The tie at exactly half goes to next.
  - Otherwise -> output 0 (prev).
- Outputs:
  - ostream_val[sel] = (count != 0). The other two ostream_val are 0.
  - ostream_msg = head entry on all three ports.
  - ostream_rdy of non-selected ports is ignored.
- Head-of-line blocking is intended: a stalled head blocks later messages even if their outputs are free.
- The message passes through unmodified. The unit never rewrites src, dest or payload.
- Reset:
  - While reset == 0: count = 0, pointers = 0, istream_rdy = 0, all ostream_val = 0. Queue storage is not reset; ostream_msg is don't-care when val = 0.
  - Asserting reset mid-transfer drops all queued messages immediately (asynchronous).
  - After deassertion, istream_rdy = 1 from the first cycle.
- Protocol: istream_msg is sampled only on enqueue. Once the unit asserts ostream_val, it holds msg and val stable until accepted; that follows from the queue state.
- Line trace: "{count}>{p|t|n|.}", showing the selected output, or "." when empty.

Decomposition:
- Shared package net_router_pkg:
  - field position constants (SRC/DEST/OPAQUE/PAYLOAD msb/lsb).
  - output port encoding constants: PORT_PREV = 0, PORT_TERM = 1, PORT_NEXT = 2.
  - route-decision function.
- One natural sub-module: net_router_queue2, a 2-entry normal queue with val/rdy on both sides. The input unit instantiates it and adds route logic plus output steering.

Test Plan:
- Reset and idle: reset = 0 for 3 cycles then 1, no input -> istream_rdy = 1, all ostream_val = 0.
- Terminal delivery: router_id = 2, send dest = 2, payload 0xDEADBEEF, all ready = 1 -> ostream_val[1] = 1 the next cycle with an identical msg. Outputs 0 and 2 stay 0.
- Route directions, router_id = 1, p_num_routers = 4:
  - dest = 2 -> output 2.
  - dest = 3 (d = 2, tie) -> output 2.
  - dest = 0 (d = 3) -> output 0.
  - Back-to-back sends achieve 1 msg/cycle.
- Backpressure: router_id = 0, ostream_rdy[2] = 0, send three dest = 1 messages -> first two enqueue, istream_rdy = 0 on the third. Raise rdy[2] -> messages drain in order, and the third is accepted the cycle after the first dequeue.
- Head-of-line: head routes to output 0 with rdy[0] = 0, second message routes to output 1 with rdy[1] = 1 -> nothing leaves until rdy[0] = 1, then order is preserved.
- Reset mid-operation: two messages queued, pulse reset low for 1 cycle asynchronously mid-cycle -> ostream_val drops immediately, count = 0 afterwards, and no stale message is emitted.
